// File: rtl/jk_counter_scheduler.sv
// Round-robin sequencer sharing one 2-bit JK up/down counter between two requesters.
// Optional wrap guard (JK_SCHED_WRAP_GUARD_EN) stops a burst early at the counter's end stop.
module jk_counter_scheduler #(
  parameter int CNT_W = 4,
  parameter int Q_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_dir,
  input  logic [CNT_W-1:0] req0_steps,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_dir,
  input  logic [CNT_W-1:0] req1_steps,
  output logic             req1_ready,
  input  logic [Q_W-1:0]   cnt_q,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             sat
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             ptr;      // 1 = requester 1 wins the next contention
  logic             dir_q;
  logic             id_q;
  logic             sat_q;
  logic [CNT_W-1:0] rem;

  logic             grant1;
  logic             acc0;
  logic             acc1;
  logic             hit;
  logic [CNT_W-1:0] acc_steps;

  always_comb begin
    grant1    = req1_valid & (~req0_valid | ptr);
    acc0      = (state == IDLE) & ~reset & req0_valid & ~grant1;
    acc1      = (state == IDLE) & ~reset & grant1;
    acc_steps = acc1 ? req1_steps : req0_steps;
  end

`ifdef JK_SCHED_WRAP_GUARD_EN
  assign hit = (state == RUN) & (dir_q ? (cnt_q == {Q_W{1'b1}}) : (cnt_q == {Q_W{1'b0}}));
`else
  logic unused_cnt_q;
  assign unused_cnt_q = ^cnt_q;
  assign hit          = 1'b0;
`endif

  // Outputs are forced quiet while reset is held, even before the state register clears.
  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign cnt_en     = (state == RUN) & ~hit & ~reset;
  assign cnt_dir    = dir_q & ~reset;
  assign busy       = (state != IDLE) & ~reset;
  assign done       = (state == DONE) & ~reset;
  assign done_id    = done & id_q;
  assign sat        = done & sat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      dir_q <= 1'b0;
      id_q  <= 1'b0;
      sat_q <= 1'b0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc0 | acc1) begin
            dir_q <= acc1 ? req1_dir : req0_dir;
            id_q  <= acc1;
            ptr   <= ~acc1;
            sat_q <= 1'b0;
            rem   <= acc_steps;
            state <= (acc_steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (hit) begin
            sat_q <= 1'b1;
            state <= DONE;
          end else begin
            rem <= rem - 1'b1;
            if (rem == CNT_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_counter_scheduler.sv
// Randomized bench with a transaction-level schedule model for jk_counter_scheduler.
module tb_jk_counter_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_dir = 1'b0, req1_valid = 1'b0, req1_dir = 1'b0;
  logic [3:0] req0_steps = 4'd0, req1_steps = 4'd0;
  logic [1:0] cnt_q = 2'd0;
  logic       req0_ready, req1_ready, cnt_en, cnt_dir, busy, done, done_id, sat;

  jk_counter_scheduler #(.CNT_W(4), .Q_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_steps(req0_steps), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_steps(req1_steps), .req1_ready(req1_ready),
    .cnt_q(cnt_q), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
    .busy(busy), .done(done), .done_id(done_id), .sat(sat)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int n_acc0 = 0, n_acc1 = 0, n_done = 0, n_en = 0;
  int done_ids[$];
  bit last_sat = 1'b0, last_id = 1'b0;
  bit en_cap = 1'b0, dir_cap = 1'b0;

  // Model: one outstanding transaction described by its schedule in cycle numbers.
  bit have_tx = 1'b0, t_dir, t_id, t_sat, m_ptr = 1'b0;
  int k, e, done_c, n, q0, room, g;
  bit x_r0, x_r1, x_en, x_busy, x_done;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // The counter itself: 2-bit, wraps freely, driven by the scheduler's enable/direction.
  always @(posedge clk) begin
    if (reset) cnt_q <= 2'd0;
    else if (en_cap) cnt_q <= dir_cap ? cnt_q + 2'd1 : cnt_q - 2'd1;
  end

  always @(negedge clk) begin
    en_cap = cnt_en;
    dir_cap = cnt_dir;
    if (cnt_en) n_en++;
    if (done) begin n_done++; last_id = done_id; last_sat = sat; done_ids.push_back(int'(done_id)); end
    x_r0 = 0; x_r1 = 0; x_en = 0; x_busy = 0; x_done = 0;
    if (reset) begin
      have_tx = 0;
      m_ptr = 0;
      chk("rst_dir", cnt_dir, 0);
    end else if (have_tx) begin
      x_busy = 1;
      x_en   = (cyc < k + e);
      x_done = (cyc == done_c);
    end else begin
      g = -1;
      if (req0_valid && req1_valid) g = int'(m_ptr);
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      if (g >= 0) begin
        x_r0 = (g == 0);
        x_r1 = (g == 1);
        if (g == 0) n_acc0++; else n_acc1++;
        n     = (g == 1) ? int'(req1_steps) : int'(req0_steps);
        t_dir = (g == 1) ? req1_dir : req0_dir;
        t_id  = (g == 1);
        m_ptr = (g == 0);
        q0    = int'(cnt_q);
        k     = cyc + 1;
        e     = n;
        t_sat = 0;
        done_c = k + n;
`ifdef JK_SCHED_WRAP_GUARD_EN
        room = t_dir ? 3 - q0 : q0;
        if (n > room) begin
          e = room;
          t_sat = 1;
          done_c = k + room + 1;
        end
`endif
        have_tx = 1;
      end
    end
    chk("ready0", req0_ready, x_r0);
    chk("ready1", req1_ready, x_r1);
    chk("busy", busy, x_busy);
    chk("cnt_en", cnt_en, x_en);
    chk("done", done, x_done);
    chk("done_id", done_id, x_done ? int'(t_id) : 0);
    chk("sat", sat, x_done ? int'(t_sat) : 0);
    if (x_en) chk("cnt_dir", cnt_dir, t_dir);
    if (x_done) have_tx = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic wait_acc(input string nm, input int id, input int target);
    for (int i = 0; i < 100 && ((id == 0) ? n_acc0 : n_acc1) < target; i++) tick();
    chk(nm, ((id == 0) ? n_acc0 : n_acc1) >= target, 1);
  endtask

  task automatic wait_done(input string nm, input int target);
    for (int i = 0; i < 100 && n_done < target; i++) tick();
    chk(nm, n_done >= target, 1);
  endtask

  initial begin
    int b, d0, p0, p1;
    tick();
    do_reset(2);

    // Up 3 from zero: three enables, counter lands on 3.
    b = n_en; d0 = n_done;
    req0_valid = 1; req0_dir = 1; req0_steps = 4'd3;
    wait_acc("t1_acc", 0, n_acc0 + 1); req0_valid = 0;
    wait_done("t1_done", d0 + 1); tick();
    chk("t1_en_cnt", n_en - b, 3);
    chk("t1_cnt_q", cnt_q, 3);
    chk("t1_id", last_id, 0);
    chk("t1_sat", last_sat, 0);

    // Contention: req0 first, then req1 wins when req0 re-presents immediately.
    do_reset(2);
    b = done_ids.size(); d0 = n_done;
    req0_valid = 1; req0_dir = 1; req0_steps = 4'd1;
    req1_valid = 1; req1_dir = 0; req1_steps = 4'd2;
    wait_acc("t2_acc0", 0, n_acc0 + 1);
    wait_acc("t2_acc1", 1, n_acc1 + 1); req1_valid = 0;
    wait_acc("t2_acc0b", 0, n_acc0 + 1); req0_valid = 0;
    wait_done("t2_done", d0 + 3); tick();
    chk("t2_id0", done_ids[b], 0);
    chk("t2_id1", done_ids[b+1], 1);
    chk("t2_id2", done_ids[b+2], 0);

    // Zero-step command: done next cycle, no enables.
    b = n_en; d0 = n_done;
    req1_valid = 1; req1_dir = 0; req1_steps = 4'd0;
    wait_acc("t3_acc", 1, n_acc1 + 1); req1_valid = 0;
    wait_done("t3_done", d0 + 1); tick();
    chk("t3_en_cnt", n_en - b, 0);
    chk("t3_id", last_id, 1);

    // Down 1 from zero: wraps to 3, or is stopped by the guard.
    do_reset(2);
    b = n_en; d0 = n_done;
    req0_valid = 1; req0_dir = 0; req0_steps = 4'd1;
    wait_acc("t4_acc", 0, n_acc0 + 1); req0_valid = 0;
    wait_done("t4_done", d0 + 1); tick();
`ifdef JK_SCHED_WRAP_GUARD_EN
    chk("t4_en_cnt", n_en - b, 0);
    chk("t4_cnt_q", cnt_q, 0);
    chk("t4_sat", last_sat, 1);
`else
    chk("t4_en_cnt", n_en - b, 1);
    chk("t4_cnt_q", cnt_q, 3);
    chk("t4_sat", last_sat, 0);
`endif

    // Reset on the second RUN cycle of a 5-step burst.
    d0 = n_done;
    req0_valid = 1; req0_dir = 1; req0_steps = 4'd5;
    wait_acc("t5_acc", 0, n_acc0 + 1); req0_valid = 0;
    tick();
    do_reset(1);
    repeat (3) tick();
    chk("t5_no_done", n_done - d0, 0);
    chk("t5_busy", busy, 0);
    req1_valid = 1; req1_dir = 1; req1_steps = 4'd1;
    wait_acc("t5_acc1", 1, n_acc1 + 1); req1_valid = 0;
    wait_done("t5_done", d0 + 1);

    // Other requester holds valid through a RUN; accepted only after done.
    repeat (2) tick();
    d0 = n_done;
    req0_valid = 1; req0_dir = 0; req0_steps = 4'd4;
    wait_acc("t6_acc0", 0, n_acc0 + 1); req0_valid = 0;
    req1_valid = 1; req1_dir = 1; req1_steps = 4'd2;
    wait_acc("t6_acc1", 1, n_acc1 + 1); req1_valid = 0;
    chk("t6_order", n_done - d0, 1);
    wait_done("t6_done", d0 + 2);

    // Random traffic with occasional resets.
    p0 = n_acc0; p1 = n_acc1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (req0_valid && n_acc0 != p0) req0_valid = $urandom_range(0, 1);
      else if (!req0_valid) req0_valid = ($urandom_range(0, 3) == 0);
      if (n_acc0 != p0 || !req0_valid) begin
        req0_dir = $urandom_range(0, 1); req0_steps = 4'($urandom_range(0, 6));
      end
      if (req1_valid && n_acc1 != p1) req1_valid = $urandom_range(0, 1);
      else if (!req1_valid) req1_valid = ($urandom_range(0, 3) == 0);
      if (n_acc1 != p1 || !req1_valid) begin
        req1_dir = $urandom_range(0, 1); req1_steps = 4'($urandom_range(0, 6));
      end
      p0 = n_acc0; p1 = n_acc1;
      reset = ($urandom_range(0, 249) == 0);
    end
    reset = 0; req0_valid = 0; req1_valid = 0;
    repeat (30) tick();
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_counter_scheduler.md
Name: jk_counter_scheduler

Overview:
- Sequencer and round-robin arbiter that shares one enable/direction-controlled 2-bit JK up/down counter between two requesters.
- Each request asks for N steps in one direction. The block grants one requester, drives the counter's enable and direction inputs for exactly N cycles, then reports completion.
- Sits between requester logic and the counter instance. Reads back the counter state, which the optional wrap guard uses.

Parameters:
- CNT_W, 4, width of the step-count field (max burst 2^CNT_W-1 steps)
- Q_W, 2, width of counter state fed back on cnt_q

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has a command
- req0_dir  in  1  requester 0 direction: 1=up, 0=down
- req0_steps  in  CNT_W  requester 0 step count
- req0_ready  out  1  requester 0 command accepted this cycle
- req1_valid  in  1  requester 1 has a command
- req1_dir  in  1  requester 1 direction
- req1_steps  in  CNT_W  requester 1 step count
- req1_ready  out  1  requester 1 command accepted this cycle
- cnt_q  in  Q_W  current counter state {A,B}
- cnt_en  out  1  counter enable (E)
- cnt_dir  out  1  counter direction (x): 1=up, 0=down
- busy  out  1  command in progress (state != IDLE)
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester that owns the done pulse
- sat  out  1  completion was an early stop by the wrap guard; valid with done

Behaviour:
- Reset behaviour:
  - Reset is synchronous and active-high on clk.
  - Outputs during reset: state=IDLE; cnt_en=0, cnt_dir=0, busy=0, done=0, done_id=0, sat=0; both ready=0.
  - Round-robin pointer resets to favour req0.
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration and acceptance:
  - Arbitration is combinational. With one valid, grant it. With both valid, grant the requester favoured by the pointer.
  - reqN_ready=1 for the granted requester only, in IDLE only. Acceptance is the edge where valid&ready=1.
  - On acceptance, latch dir, steps and id, and set the pointer to favour the other requester.
  - steps!=0: go to RUN with remaining=steps.
  - steps==0: go to DONE directly; no cnt_en pulse.
- RUN:
  - cnt_en=1 and cnt_dir=latched dir, decoded combinationally from registered state.
  - Each cycle, remaining decrements by 1. When remaining==1, the next state is DONE.
  - Exactly N enable cycles are issued.
- DONE:
  - done=1 and done_id=latched id for exactly one cycle; cnt_en=0. Next state is IDLE.
  - No new acceptance occurs in DONE.
- Latency: with acceptance at edge k, cnt_en is high for the N cycles after edge k, done is high in the cycle after the last enable, and the earliest next acceptance is the edge that ends the done cycle + 1 (IDLE cycle).
- cnt_dir outside RUN: holds its last value. Only cnt_en qualifies it.
- Request lines while busy: ignored, with ready=0. Requesters hold valid/dir/steps stable until ready.
- Pointer: updates only on acceptance. A lone requester is granted regardless of the pointer.
- Counter state: the counter wraps freely (3→0 up, 0→3 down) unless the guard is enabled.
- Reset mid-operation: returns to IDLE next edge. Remaining steps are discarded and no done pulse is issued. cnt_en is 0 from the reset cycle onward.
- Mutual exclusion: req0_ready and req1_ready are never both 1.

Optional Feature:
- Macro: JK_SCHED_WRAP_GUARD_EN.
- Defined:
  - In RUN, if (dir=1 and cnt_q=all-ones) or (dir=0 and cnt_q=0), cnt_en is forced 0 that cycle and the FSM goes to DONE with sat=1. Remaining steps are dropped.
  - A guard hit on the first RUN cycle yields zero enables.
- Undefined: the guard logic is absent, sat is tied 0, and the counter wraps.

Test Plan:
- After reset with counter=0, req0 up 3 steps → req0_ready one cycle, cnt_en high 3 cycles with cnt_dir=1, counter=3, then done=1 with done_id=0 and sat=0.
- req0 and req1 both valid right after reset (req0 up 1, req1 down 2) → req0 served first, then req1. A second contention → req1 granted first.
- req1 with steps=0 → accepted, no cnt_en, done pulse the next cycle with done_id=1.
- Counter=0, req0 down 1, macro undefined → one enable, counter=3, sat=0. Macro defined → zero enables, done with sat=1, counter stays 0.
- Reset asserted on the 2nd cycle of a 5-step RUN → cnt_en=0 from the reset cycle, no done, busy=0, and the next request is accepted from IDLE normally.
- Valid held during RUN by the other requester → ready stays 0 until IDLE, then it is accepted.
